// File: rtl/cm_fifo_sync.sv
// Single-clock valid/ready FIFO with arbitrary (non power-of-two) depth.
// The pointers wrap at DEPTH-1. The occupancy counter drives o_full and o_empty directly.
module cm_fifo_sync #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  input  logic [DW-1:0] i_dat,
  output logic          o_rdy,
  output logic          o_vld,
  output logic [DW-1:0] o_dat,
  input  logic          i_rdy,
  output logic [CW-1:0] o_cnt,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [PW-1:0] PtrMax = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CntMax = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty, push, pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] ptr);
    return (ptr == PtrMax) ? '0 : ptr + PW'(1);
  endfunction

  // Full/empty come from registered state only, so i_rdy never reaches o_rdy.
  always_comb begin
    full  = (cnt_q == CntMax);
    empty = (cnt_q == '0);
    push  = i_vld & ~full;
    pop   = ~empty & i_rdy;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately left unreset; o_dat is meaningless while o_vld is low.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_dat;
  end

  always_comb begin
    o_rdy   = ~full;
    o_vld   = ~empty;
    o_dat   = mem_q[rd_ptr_q];
    o_cnt   = cnt_q;
    o_full  = full;
    o_empty = empty;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full));
      assert (!(pop && empty));
      assert (cnt_q <= CntMax);
      assert (wr_ptr_q <= PtrMax);
      assert (rd_ptr_q <= PtrMax);
    end
  end
`endif

endmodule

// File: tb/tb_cm_fifo_sync.sv
// Scoreboard bench for cm_fifo_sync at depths 4 (fill/drain, full, reset), 3 (streaming wrap)
// and 5 (random backpressure).
module tb_cm_fifo_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DEPTH=4
  logic       a_vld, a_rdy, a_ovld, a_irdy, a_full, a_empty;
  logic [7:0] a_dat, a_odat;
  logic [2:0] a_cnt;
  // Instance B: DEPTH=3
  logic       b_vld, b_rdy, b_ovld, b_irdy, b_full, b_empty;
  logic [7:0] b_dat, b_odat;
  logic [1:0] b_cnt;
  // Instance C: DEPTH=5
  logic       c_vld, c_rdy, c_ovld, c_irdy, c_full, c_empty;
  logic [7:0] c_dat, c_odat;
  logic [2:0] c_cnt;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] exp_c[$];

  cm_fifo_sync #(.DW(8), .DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .i_vld(a_vld), .i_dat(a_dat), .o_rdy(a_rdy), .o_vld(a_ovld),
    .o_dat(a_odat), .i_rdy(a_irdy), .o_cnt(a_cnt), .o_full(a_full), .o_empty(a_empty)
  );
  cm_fifo_sync #(.DW(8), .DEPTH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .i_vld(b_vld), .i_dat(b_dat), .o_rdy(b_rdy), .o_vld(b_ovld),
    .o_dat(b_odat), .i_rdy(b_irdy), .o_cnt(b_cnt), .o_full(b_full), .o_empty(b_empty)
  );
  cm_fifo_sync #(.DW(8), .DEPTH(5)) u_c (
    .clk(clk), .rst_n(rst_n), .i_vld(c_vld), .i_dat(c_dat), .o_rdy(c_rdy), .o_vld(c_ovld),
    .o_dat(c_odat), .i_rdy(c_irdy), .o_cnt(c_cnt), .o_full(c_full), .o_empty(c_empty)
  );

  // Push one word into A with i_rdy low; the scoreboard records it when accepted.
  task automatic push_a(input logic [7:0] d);
    @(negedge clk);
    a_irdy = 1'b0;
    a_vld  = 1'b1;
    a_dat  = d;
    checks++;
    if (a_rdy !== 1'b1) begin
      errors++;
      $display("FAIL push_a_rdy: o_rdy=%b required 1", a_rdy);
    end else begin
      exp_a.push_back(d);
    end
  endtask

  // Drain A with i_rdy high, checking order; ends with o_empty checked.
  task automatic drain_a(input string tag);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      a_vld  = 1'b0;
      a_irdy = 1'b1;
      if (!a_ovld) break;
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL %s_extra: o_dat=%h required nothing", tag, a_odat);
      end else begin
        logic [7:0] e;
        e = exp_a.pop_front();
        if (a_odat !== e) begin
          errors++;
          $display("FAIL %s_data: o_dat=%h required %h", tag, a_odat, e);
        end
      end
    end
    checks++;
    if (a_empty !== 1'b1 || exp_a.size() != 0) begin
      errors++;
      $display("FAIL %s_empty: o_empty=%b left=%0d required 1 and 0", tag, a_empty, exp_a.size());
    end
    a_irdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ovld, a_rdy, a_empty, a_full} !== 4'b0110) begin
      errors++;
      $display("FAIL reset_flags: vld,rdy,empty,full=%b required 0110",
               {a_ovld, a_rdy, a_empty, a_full});
    end
    checks++;
    if (a_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_cnt: o_cnt=%0d required 0", a_cnt);
    end
    checks++;
    if (b_ovld !== 1'b0 || c_ovld !== 1'b0 || b_rdy !== 1'b1 || c_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_bc: b vld/rdy=%b%b c vld/rdy=%b%b required 01 01",
               b_ovld, b_rdy, c_ovld, c_rdy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    push_a(8'h44);
    @(negedge clk);
    a_vld = 1'b0;
    checks++;
    if (a_full !== 1'b1 || a_rdy !== 1'b0 || a_cnt !== 3'd4) begin
      errors++;
      $display("FAIL fill_full: full=%b rdy=%b cnt=%0d required 1 0 4", a_full, a_rdy, a_cnt);
    end
    drain_a("fill_drain");
  endtask

  task automatic test_full_simul();
    logic [7:0] e;
    for (int i = 0; i < 4; i++) push_a(8'h50 + 8'(i));
    @(negedge clk);
    a_vld  = 1'b1;
    a_dat  = 8'h99;
    a_irdy = 1'b1;
    checks++;
    if (a_rdy !== 1'b0 || a_cnt !== 3'd4) begin
      errors++;
      $display("FAIL full_refuse: rdy=%b cnt=%0d required 0 4", a_rdy, a_cnt);
    end
    e = exp_a.pop_front();
    checks++;
    if (a_odat !== e) begin
      errors++;
      $display("FAIL full_pop0: o_dat=%h required %h", a_odat, e);
    end
    @(negedge clk);
    checks++;
    if (a_rdy !== 1'b1 || a_cnt !== 3'd3) begin
      errors++;
      $display("FAIL full_after_pop: rdy=%b cnt=%0d required 1 3", a_rdy, a_cnt);
    end
    e = exp_a.pop_front();
    checks++;
    if (a_odat !== e) begin
      errors++;
      $display("FAIL full_pop1: o_dat=%h required %h", a_odat, e);
    end
    exp_a.push_back(8'h99);
    @(negedge clk);
    a_vld  = 1'b0;
    a_irdy = 1'b0;
    checks++;
    if (a_cnt !== 3'd3) begin
      errors++;
      $display("FAIL full_both: cnt=%0d required 3", a_cnt);
    end
    drain_a("full_drain");
  endtask

  task automatic test_stream();
    int sent = 0;
    int got = 0;
    for (int n = 0; n < 30 && got < 10; n++) begin
      @(negedge clk);
      b_irdy = 1'b1;
      if (sent >= 1) begin
        checks++;
        if (b_cnt !== 2'd1) begin
          errors++;
          $display("FAIL stream_cnt: o_cnt=%0d required 1 (cycle %0d)", b_cnt, n);
        end
      end
      if (b_ovld) begin
        logic [7:0] e;
        checks++;
        e = (exp_b.size() != 0) ? exp_b.pop_front() : 8'hxx;
        if (b_odat !== e) begin
          errors++;
          $display("FAIL stream_data: o_dat=%h required %h", b_odat, e);
        end
        got++;
      end
      if (sent < 10 && b_rdy) begin
        b_vld = 1'b1;
        b_dat = 8'(sent);
        exp_b.push_back(8'(sent));
        sent++;
      end else begin
        b_vld = 1'b0;
      end
    end
    b_vld = 1'b0;
    checks++;
    if (got != 10 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got=%0d left=%0d required 10 0", got, exp_b.size());
    end
  endtask

  task automatic test_backpressure();
    logic       hold = 1'b0;
    logic [7:0] hold_dat = '0;
    int         popped = 0;
    for (int n = 0; n < 1000 + 20; n++) begin
      @(negedge clk);
      checks++;
      if (c_cnt !== 3'(exp_c.size()) || c_ovld !== (exp_c.size() != 0) ||
          c_rdy !== (exp_c.size() != 5)) begin
        errors++;
        $display("FAIL bp_state: cnt=%0d vld=%b rdy=%b model=%0d", c_cnt, c_ovld, c_rdy,
                 exp_c.size());
      end
      if (hold) begin
        checks++;
        if (c_odat !== hold_dat) begin
          errors++;
          $display("FAIL bp_stable: o_dat=%h required %h", c_odat, hold_dat);
        end
      end
      if (n < 1000) begin
        c_irdy = 1'($urandom_range(0, 1));
        c_vld  = 1'($urandom_range(0, 1));
        c_dat  = 8'($urandom);
      end else begin
        c_irdy = 1'b1;
        c_vld  = 1'b0;
      end
      if (c_ovld && c_irdy) begin
        logic [7:0] e;
        checks++;
        e = (exp_c.size() != 0) ? exp_c.pop_front() : 8'hxx;
        if (c_odat !== e) begin
          errors++;
          $display("FAIL bp_data: o_dat=%h required %h", c_odat, e);
        end
        popped++;
      end
      if (c_vld && c_rdy) exp_c.push_back(c_dat);
      hold     = c_ovld && !c_irdy;
      hold_dat = c_odat;
    end
    c_irdy = 1'b0;
    checks++;
    if (exp_c.size() != 0 || popped < 100) begin
      errors++;
      $display("FAIL bp_end: left=%0d popped=%0d required 0 and >=100", exp_c.size(), popped);
    end
  endtask

  task automatic test_reset_mid();
    push_a(8'h01);
    push_a(8'h02);
    @(negedge clk);
    a_vld = 1'b0;
    checks++;
    if (a_cnt !== 3'd2) begin
      errors++;
      $display("FAIL mid_pre: cnt=%0d required 2", a_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_ovld !== 1'b0 || a_cnt !== 3'd0 || a_empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_async: vld=%b cnt=%0d empty=%b required 0 0 1", a_ovld, a_cnt, a_empty);
    end
    exp_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_a(8'hA5);
    @(negedge clk);
    a_vld = 1'b0;
    checks++;
    if (a_ovld !== 1'b1 || a_odat !== 8'hA5 || a_cnt !== 3'd1) begin
      errors++;
      $display("FAIL mid_after: vld=%b dat=%h cnt=%0d required 1 a5 1", a_ovld, a_odat, a_cnt);
    end
    drain_a("mid_drain");
  endtask

  initial begin
    a_vld = 0; a_dat = '0; a_irdy = 0;
    b_vld = 0; b_dat = '0; b_irdy = 0;
    c_vld = 0; c_dat = '0; c_irdy = 0;
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_stream();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
